neuron_o_backprop: RTL and testbench
====================================

Name: neuron_o_backprop

Overview:
Backward-pass counterpart of the output neuron. It takes the forward output y, the target and the forward operands (a_1, a_2, w_1, w_2, b). From these it computes the output delta for a tanh activation and the SGD-updated weights and bias. It sits after the forward output neuron in the training datapath. Its delta output feeds hidden-layer backprop blocks. All arithmetic is done in Q8.24 through one shared multiplier, sequenced by an FSM with a start/done handshake.

Parameters:
WIDTH, 32, data word width (signed two's complement)
FBITS, 24, fractional bits; ONE = 1 << FBITS = 0x01000000

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = FSM advances; 0 = every register holds
start  input  1  request; sampled only in IDLE
y  input  WIDTH  forward tanh output, Q8.24
target  input  WIDTH  desired output, Q8.24
a_1, a_2  input  WIDTH  forward inputs, Q8.24
w_1, w_2  input  WIDTH  current weights, Q8.24
b  input  WIDTH  current bias, Q8.24
lr  input  WIDTH  learning rate, Q8.24
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse when results are valid
delta  output  WIDTH  (y-target)*(1-y^2), registered
w_1_new, w_2_new, b_new  output  WIDTH  updated parameters, registered

Behaviour:
- Reset, active-low and asynchronous. While reset=0: FSM=IDLE, busy=0, done=0, and delta, w_1_new, w_2_new, b_new plus all internal registers are 0. Asserting reset mid-operation aborts the operation with no done pulse.
- Multiply, identical to the codebase mult_Q: full 2*WIDTH signed product, arithmetic shift right by FBITS, truncate to WIDTH. No rounding, no saturation.
- Add/sub: wrap modulo 2^WIDTH.
- Exactly one multiplier is instantiated and shared across states.
- When enable=0, the FSM, all registers, busy and done hold. A done pulse is therefore stretched for as long as the stall lasts.
- FSM, one state per edge when enable=1:
  - IDLE: when start=1, capture all data inputs into internal registers, then go to SQ. Inputs are ignored after capture.
  - SQ: ysq = y*y; err = y - target; go to DEL.
  - DEL: dlt = err * (ONE - ysq); go to SCL.
  - SCL: ld = lr * dlt; go to G1.
  - G1: gw1 = ld * a_1; go to G2.
  - G2: gw2 = ld * a_2; go to UPD.
  - UPD: w_1_new = w_1 - gw1; w_2_new = w_2 - gw2; b_new = b - ld; delta = dlt; done=1 for the next cycle; go to IDLE.
- Latency: with start sampled at edge E0 and no stalls, done=1 and outputs are valid in the cycle after edge E0+6.
- busy=1 in states SQ through UPD. It is 0 in IDLE, including the done cycle.
- start while busy=1 is ignored and not queued.
- start held high through done starts a new operation at the edge ending the done cycle. Throughput is one result per 7 cycles.
- Outputs hold their values between done pulses.

Test Plan:
- Reset: reset=0 mid-run -> busy=0, done=0, all outputs 0x00000000. Release reset -> FSM idle, no spurious done.
- Nominal update: y=0x00800000, target=0, lr=0x00800000, a_1=0x01000000, a_2=0xFE000000, w_1=0x01000000, w_2=0, b=0. Required: delta=0x00600000, w_1_new=0x00D00000, w_2_new=0x00600000, b_new=0xFFD00000, done exactly 7 cycles after the start cycle, single-cycle pulse.
- Zero error: y=target=0x00400000 with arbitrary other inputs -> delta=0 and w_1_new/w_2_new/b_new equal w_1/w_2/b.
- Busy protection: pulse start again and change all inputs during SQ..G2 -> results identical to the nominal case, exactly one done. start held high -> a second done arrives 7 cycles after the first.
- Reset mid-op: drive reset=0 while in G1 -> outputs clear, no done. A restart with nominal stimulus gives the nominal results.
- Stall: enable=0 for 3 cycles during SCL -> done 3 cycles later than nominal, same values. enable=0 during the done cycle -> done held high until enable returns.

Source files
------------

// File: rtl/neuron_o_backprop.sv
// rtl/neuron_o_backprop.sv - Q8.24 tanh output-neuron backprop: delta and SGD update through one shared multiplier
module neuron_o_backprop #(
    parameter int WIDTH = 32,
    parameter int FBITS = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] a_2,
    input  logic [WIDTH-1:0] w_1,
    input  logic [WIDTH-1:0] w_2,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] lr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] delta,
    output logic [WIDTH-1:0] w_1_new,
    output logic [WIDTH-1:0] w_2_new,
    output logic [WIDTH-1:0] b_new
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FBITS;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ   = 3'd1,
        DEL  = 3'd2,
        SCL  = 3'd3,
        G1   = 3'd4,
        G2   = 3'd5,
        UPD  = 3'd6
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] y_r, target_r, a_1_r, a_2_r, w_1_r, w_2_r, b_r, lr_r;
    logic [WIDTH-1:0] ysq, err, dlt, ld, gw1, gw2;

    logic [WIDTH-1:0]   mul_a, mul_b, mul_q;
    logic [2*WIDTH-1:0] prod;
    logic               unused_prod_bits;

    // Single shared multiplier: operands steered by state, result floors toward -inf.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            SQ:  begin mul_a = y_r;  mul_b = y_r;       end
            DEL: begin mul_a = err;  mul_b = ONE - ysq; end
            SCL: begin mul_a = lr_r; mul_b = dlt;       end
            G1:  begin mul_a = ld;   mul_b = a_1_r;     end
            G2:  begin mul_a = ld;   mul_b = a_2_r;     end
            default: ;
        endcase
    end

    assign prod  = {{WIDTH{mul_a[WIDTH-1]}}, mul_a} * {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
    assign mul_q = prod[FBITS +: WIDTH];
    assign unused_prod_bits = ^{prod[2*WIDTH-1:FBITS+WIDTH], prod[FBITS-1:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SQ;
            SQ:      state_next = DEL;
            DEL:     state_next = SCL;
            SCL:     state_next = G1;
            G1:      state_next = G2;
            G2:      state_next = UPD;
            UPD:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            y_r      <= '0;
            target_r <= '0;
            a_1_r    <= '0;
            a_2_r    <= '0;
            w_1_r    <= '0;
            w_2_r    <= '0;
            b_r      <= '0;
            lr_r     <= '0;
            ysq      <= '0;
            err      <= '0;
            dlt      <= '0;
            ld       <= '0;
            gw1      <= '0;
            gw2      <= '0;
            delta    <= '0;
            w_1_new  <= '0;
            w_2_new  <= '0;
            b_new    <= '0;
            done     <= 1'b0;
        end else if (enable) begin
            done <= (state == UPD);
            case (state)
                IDLE: begin
                    if (start) begin
                        y_r      <= y;
                        target_r <= target;
                        a_1_r    <= a_1;
                        a_2_r    <= a_2;
                        w_1_r    <= w_1;
                        w_2_r    <= w_2;
                        b_r      <= b;
                        lr_r     <= lr;
                    end
                end
                SQ: begin
                    ysq <= mul_q;
                    err <= y_r - target_r;
                end
                DEL: dlt <= mul_q;
                SCL: ld  <= mul_q;
                G1:  gw1 <= mul_q;
                G2:  gw2 <= mul_q;
                UPD: begin
                    w_1_new <= w_1_r - gw1;
                    w_2_new <= w_2_r - gw2;
                    b_new   <= b_r - ld;
                    delta   <= dlt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_o_backprop.sv
// tb/tb_neuron_o_backprop.sv - directed vector bench for neuron_o_backprop
module tb_neuron_o_backprop;

    logic        clock = 1'b0;
    logic        reset, enable, start;
    logic [31:0] y, target, a_1, a_2, w_1, w_2, b, lr;
    logic        busy, done;
    logic [31:0] delta, w_1_new, w_2_new, b_new;

    neuron_o_backprop #(.WIDTH(32), .FBITS(24)) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .start   (start),
        .y       (y),
        .target  (target),
        .a_1     (a_1),
        .a_2     (a_2),
        .w_1     (w_1),
        .w_2     (w_2),
        .b       (b),
        .lr      (lr),
        .busy    (busy),
        .done    (done),
        .delta   (delta),
        .w_1_new (w_1_new),
        .w_2_new (w_2_new),
        .b_new   (b_new)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] y, target, a_1, a_2, w_1, w_2, b, lr;
        logic [31:0] e_delta, e_w1, e_w2, e_b;
    } vec_t;

    vec_t vecs[4];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input int i);
        y = vecs[i].y; target = vecs[i].target; a_1 = vecs[i].a_1; a_2 = vecs[i].a_2;
        w_1 = vecs[i].w_1; w_2 = vecs[i].w_2; b = vecs[i].b; lr = vecs[i].lr;
    endtask

    task automatic check_outputs(input int i, input string tag);
        check({tag, "_delta"}, delta,   vecs[i].e_delta);
        check({tag, "_w1"},    w_1_new, vecs[i].e_w1);
        check({tag, "_w2"},    w_2_new, vecs[i].e_w2);
        check({tag, "_b"},     b_new,   vecs[i].e_b);
    endtask

    // Caller is at a negedge; returns number of cycles from the start cycle to done.
    task automatic run_vec(input int i, input string tag);
        int lat;
        apply(i);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd7);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check_outputs(i, tag);
        @(negedge clock);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, dones, first, second;

        // y, target, a_1, a_2, w_1, w_2, b, lr, delta, w_1_new, w_2_new, b_new
        vecs[0] = '{32'h0080_0000, 32'h0000_0000, 32'h0100_0000, 32'hFE00_0000,
                    32'h0100_0000, 32'h0000_0000, 32'h0000_0000, 32'h0080_0000,
                    32'h0060_0000, 32'h00D0_0000, 32'h0060_0000, 32'hFFD0_0000};
        vecs[1] = '{32'h0040_0000, 32'h0040_0000, 32'h0030_0000, 32'hFF00_0000,
                    32'h1234_5678, 32'hFEDC_BA98, 32'h00AB_CDEF, 32'h0080_0000,
                    32'h0000_0000, 32'h1234_5678, 32'hFEDC_BA98, 32'h00AB_CDEF};
        vecs[2] = '{32'h0000_0000, 32'h0100_0000, 32'h0080_0000, 32'h0200_0000,
                    32'h0000_0000, 32'h0100_0000, 32'h0010_0000, 32'h0040_0000,
                    32'hFF00_0000, 32'h0020_0000, 32'h0180_0000, 32'h0050_0000};
        // Tiny negative values: arithmetic shift floors toward -inf, no rounding.
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0100_0000,
                    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0100_0000,
                    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};

        reset = 1'b0; enable = 1'b1; start = 1'b0;
        y = '0; target = '0; a_1 = '0; a_2 = '0; w_1 = '0; w_2 = '0; b = '0; lr = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_delta", delta, 32'd0);
        check("rst_w1", w_1_new, 32'd0);
        check("rst_w2", w_2_new, 32'd0);
        check("rst_b", b_new, 32'd0);
        reset = 1'b1;
        dones = 0;
        repeat (3) begin
            @(negedge clock);
            if (done || busy) dones++;
        end
        check("post_rst_idle", 32'(dones), 32'd0);

        for (int i = 0; i < 4; i++) run_vec(i, $sformatf("vec%0d", i));

        // Busy protection: extra start pulses and input churn during SQ..G2.
        apply(0);
        start = 1'b1;
        dones = 0; first = -1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (done) begin dones++; if (first < 0) first = k; end
            if (k <= 5) begin
                y = $urandom; target = $urandom; a_1 = $urandom; a_2 = $urandom;
                w_1 = $urandom; w_2 = $urandom; b = $urandom; lr = $urandom;
                start = (k == 2 || k == 4);
            end else begin
                start = 1'b0;
            end
        end
        check("prot_latency", 32'(first), 32'd7);
        check("prot_dones", 32'(dones), 32'd1);
        check_outputs(0, "prot");

        // start held high: back-to-back operations every 7 cycles.
        apply(0);
        start = 1'b1;
        first = -1; second = -1; dones = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (done) begin
                dones++;
                if (first < 0) begin
                    first = k;
                    check("held_busy_in_done", 32'(busy), 32'd0);
                end else if (second < 0) begin
                    second = k;
                    start = 1'b0;
                end
            end
        end
        check("held_first", 32'(first), 32'd7);
        check("held_second", 32'(second), 32'd14);
        check("held_dones", 32'(dones), 32'd2);
        check_outputs(0, "held");

        // Reset asserted while in G1 aborts without done.
        apply(0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_delta", delta, 32'd0);
        check("abort_w1", w_1_new, 32'd0);
        check("abort_w2", w_2_new, 32'd0);
        check("abort_b", b_new, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clock);
            if (done || busy) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_vec(0, "restart");

        // Stall 3 cycles while in SCL, then hold the done cycle with enable=0.
        apply(2);
        start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            lat = k;
            if (k == 1) start = 1'b0;
            if (k == 3) enable = 1'b0;
            if (k == 6) enable = 1'b1;
            if (done) break;
        end
        check("stall_latency", 32'(lat), 32'd10);
        check_outputs(2, "stall");
        enable = 1'b0;
        dones = 0;
        repeat (3) begin
            @(negedge clock);
            if (done) dones++;
        end
        check("stretch_done_held", 32'(dones), 32'd3);
        enable = 1'b1;
        @(negedge clock);
        check("stretch_done_release", 32'(done), 32'd0);
        check_outputs(2, "hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
